// File: rtl/video_lcd_pkg.sv
// Shared definitions for the 800x480 LCD timing path. The generator and the
// capture front end both use these.
package video_lcd_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } state_t;

  localparam int POS_WIDTH_DEF = 11;

  // 800x480 panel timing, in pixel clocks / lines
  localparam int HLINE  = 1056;
  localparam int HBACK  = 46;
  localparam int HFRONT = 210;
  localparam int VLINE  = 525;
  localparam int VBACK  = 23;
  localparam int VFRONT = 22;

endpackage

// File: rtl/video_sample_sync.sv
// Brings the pixel-clock level and DE into the system domain and turns each
// pixel-clock rise into a one-cycle strobe with the DE captured alongside it.
module video_sample_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_vga_clock,
  input  logic i_data_enable,
  output logic strobe,
  output logic data_enable
);

  logic [1:0] clk_sync;
  logic [1:0] de_sync;
  logic       clk_prev;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      clk_sync <= 2'b00;
      de_sync  <= 2'b00;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], i_vga_clock};
      de_sync  <= {de_sync[0], i_data_enable};
      clk_prev <= clk_sync[1];
    end
  end

  // DE comes from the same stage as the edge, so it lines up with the strobe
  assign strobe      = clk_sync[1] & ~clk_prev;
  assign data_enable = de_sync[1];

endmodule

// File: rtl/video_lcd_capture.sv
// LCD parallel-interface receiver: recovers scan position and framing from
// pixel-clock level plus DE, measures active resolution and reports lock.
module video_lcd_capture
  import video_lcd_pkg::*;
#(
  parameter int POS_WIDTH   = POS_WIDTH_DEF,
  parameter int VGAP        = 512,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_vga_clock,
  input  logic                 i_data_enable,
  output logic                 o_pixel_valid,
  output logic [POS_WIDTH-1:0] o_pos_x,
  output logic [POS_WIDTH-1:0] o_pos_y,
  output logic                 o_frame_start,
  output logic [POS_WIDTH-1:0] o_width,
  output logic [POS_WIDTH-1:0] o_height,
  output logic                 o_locked,
  output logic                 o_error,
  output state_t               o_state
);

  localparam int GAP_W    = $clog2(VGAP + 1);
  localparam int LOCK_MAX = LOCK_FRAMES - 1;
  localparam int LOCK_W   = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [POS_WIDTH-1:0] POS_MAX = {POS_WIDTH{1'b1}};

  logic strobe;
  logic de;

  video_sample_sync u_sync (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_vga_clock  (i_vga_clock),
    .i_data_enable(i_data_enable),
    .strobe       (strobe),
    .data_enable  (de)
  );

  state_t                 state_q, state_n;
  logic [POS_WIDTH-1:0]   x_q, x_n, y_q, y_n, ref_w_q, ref_w_n;
  logic [POS_WIDTH-1:0]   prev_w_q, prev_w_n, prev_h_q, prev_h_n;
  logic [GAP_W-1:0]       gap_q, gap_n;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_n;
  logic                   line_err_q, line_err_n, prev_valid_q, prev_valid_n;
  logic [POS_WIDTH-1:0]   pos_x_n, pos_y_n, width_n, height_n;
  logic                   pix_n, fs_n, err_n, locked_n;
  logic [POS_WIDTH-1:0]   frame_h;
  logic                   frame_match;
  logic                   overflow;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= HUNT;
      x_q           <= '0;
      y_q           <= '0;
      ref_w_q       <= '0;
      prev_w_q      <= '0;
      prev_h_q      <= '0;
      gap_q         <= '0;
      lock_cnt_q    <= '0;
      line_err_q    <= 1'b0;
      prev_valid_q  <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_pos_x       <= '0;
      o_pos_y       <= '0;
      o_frame_start <= 1'b0;
      o_width       <= '0;
      o_height      <= '0;
      o_locked      <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state_q       <= state_n;
      x_q           <= x_n;
      y_q           <= y_n;
      ref_w_q       <= ref_w_n;
      prev_w_q      <= prev_w_n;
      prev_h_q      <= prev_h_n;
      gap_q         <= gap_n;
      lock_cnt_q    <= lock_cnt_n;
      line_err_q    <= line_err_n;
      prev_valid_q  <= prev_valid_n;
      o_pixel_valid <= pix_n;
      o_pos_x       <= pos_x_n;
      o_pos_y       <= pos_y_n;
      o_frame_start <= fs_n;
      o_width       <= width_n;
      o_height      <= height_n;
      o_locked      <= locked_n;
      o_error       <= err_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    x_n          = x_q;
    y_n          = y_q;
    ref_w_n      = ref_w_q;
    prev_w_n     = prev_w_q;
    prev_h_n     = prev_h_q;
    gap_n        = gap_q;
    lock_cnt_n   = lock_cnt_q;
    line_err_n   = line_err_q;
    prev_valid_n = prev_valid_q;
    pos_x_n      = o_pos_x;
    pos_y_n      = o_pos_y;
    width_n      = o_width;
    height_n     = o_height;
    locked_n     = o_locked;
    pix_n        = 1'b0;
    fs_n         = 1'b0;
    err_n        = 1'b0;
    overflow     = 1'b0;
    frame_h      = y_q + 1'b1;
    // a frame only counts toward lock if the one before it was clean too
    frame_match  = prev_valid_q && (ref_w_q == prev_w_q) && (frame_h == prev_h_q) && !line_err_q;

    if (strobe) begin
      case (state_q)
        HUNT: begin
          if (de) begin
            gap_n = '0;
          end else if (gap_q == GAP_W'(VGAP - 1)) begin
            gap_n   = '0;
            state_n = VBLANK;
          end else begin
            gap_n = gap_q + 1'b1;
          end
        end
        VBLANK: begin
          if (de) begin
            pix_n      = 1'b1;
            fs_n       = 1'b1;
            pos_x_n    = '0;
            pos_y_n    = '0;
            x_n        = POS_WIDTH'(1);
            y_n        = '0;
            line_err_n = 1'b0;
            state_n    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (de) begin
            if (x_q == POS_MAX) begin
              overflow = 1'b1;
            end else begin
              pix_n   = 1'b1;
              pos_x_n = x_q;
              pos_y_n = y_q;
              x_n     = x_q + 1'b1;
            end
          end else begin
            if (y_q == '0) begin
              ref_w_n = x_q;
            end else if (x_q != ref_w_q) begin
              line_err_n = 1'b1;
              err_n      = 1'b1;
            end
            gap_n   = GAP_W'(1);
            state_n = HBLANK;
          end
        end
        HBLANK: begin
          if (de) begin
            if (y_q == POS_MAX) begin
              overflow = 1'b1;
            end else begin
              y_n     = y_q + 1'b1;
              pix_n   = 1'b1;
              pos_x_n = '0;
              pos_y_n = y_q + 1'b1;
              x_n     = POS_WIDTH'(1);
              state_n = ACTIVE;
            end
          end else if (gap_q == GAP_W'(VGAP - 1)) begin
            height_n     = frame_h;
            width_n      = ref_w_q;
            prev_w_n     = ref_w_q;
            prev_h_n     = frame_h;
            prev_valid_n = !line_err_q;
            if (!frame_match) lock_cnt_n = '0;
            else if (lock_cnt_q != LOCK_W'(LOCK_MAX)) lock_cnt_n = lock_cnt_q + 1'b1;
            locked_n     = (lock_cnt_n >= LOCK_W'(LOCK_MAX));
            gap_n        = '0;
            state_n      = VBLANK;
          end else begin
            gap_n = gap_q + 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    if (overflow) begin
      err_n        = 1'b1;
      locked_n     = 1'b0;
      lock_cnt_n   = '0;
      prev_valid_n = 1'b0;
      gap_n        = '0;
      state_n      = HUNT;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_video_lcd_capture.sv
// Directed bench for video_lcd_capture with a shrunk blanking threshold and a
// 4-cycle pixel period.
module tb_video_lcd_capture;
  import video_lcd_pkg::*;

  localparam int PW  = 11;
  localparam int GAP = 16;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_vga_clock = 1'b0;
  logic          i_data_enable = 1'b0;
  logic          o_pixel_valid;
  logic [PW-1:0] o_pos_x;
  logic [PW-1:0] o_pos_y;
  logic          o_frame_start;
  logic [PW-1:0] o_width;
  logic [PW-1:0] o_height;
  logic          o_locked;
  logic          o_error;
  state_t        o_state;

  always #5 i_clock = ~i_clock;

  video_lcd_capture #(.POS_WIDTH(PW), .VGAP(GAP), .LOCK_FRAMES(2)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_vga_clock  (i_vga_clock),
    .i_data_enable(i_data_enable),
    .o_pixel_valid(o_pixel_valid),
    .o_pos_x      (o_pos_x),
    .o_pos_y      (o_pos_y),
    .o_frame_start(o_frame_start),
    .o_width      (o_width),
    .o_height     (o_height),
    .o_locked     (o_locked),
    .o_error      (o_error),
    .o_state      (o_state)
  );

  int checks = 0;
  int errors = 0;
  int pix_cnt = 0;
  int err_cnt = 0;
  logic prev_pv = 1'b0;
  logic prev_err = 1'b0;
  logic [2*PW:0] exp_q[$];

  typedef struct {
    int lw; int l2w; int nl; int ew; int eh; bit el; int eerr;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every emitted pixel must match the head of the expected queue
  always @(negedge i_clock) begin
    logic [2*PW:0] e;
    if (o_pixel_valid) begin
      pix_cnt++;
      chk("pv_one_cycle", 32'(prev_pv), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel actual=(%0d,%0d) required=none at %0t", o_pos_x, o_pos_y, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pixel_fs_x_y", 32'({o_frame_start, o_pos_x, o_pos_y}), 32'(e));
      end
    end else if (o_frame_start) begin
      chk("fs_without_pixel", 32'(o_frame_start), 32'd0);
    end
    if (o_error) begin
      err_cnt++;
      chk("err_one_cycle", 32'(prev_err), 32'd0);
    end
    prev_pv  = o_pixel_valid;
    prev_err = o_error;
  end

  function automatic logic [2*PW:0] pix(input bit fs, input int x, input int y);
    return {fs, PW'(x), PW'(y)};
  endfunction

  // one pixel-clock period: 2 cycles high, 2 low; starts and ends at posedge+1
  task automatic strobe(input logic de);
    i_vga_clock   = 1'b1;
    i_data_enable = de;
    repeat (2) @(posedge i_clock);
    #1 i_vga_clock = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
  endtask

  // first pixel of a frame, checking exact output timing against sample edge N
  task automatic lat_strobe();
    i_vga_clock   = 1'b1;
    i_data_enable = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock) chk("lat_after_n", 32'(o_pixel_valid), 32'd0);
    @(posedge i_clock);
    #1 i_vga_clock = 1'b0;
    @(negedge i_clock) chk("lat_after_n1", 32'(o_pixel_valid), 32'd0);
    @(posedge i_clock);
    @(negedge i_clock);
    chk("lat_pv_n2", 32'(o_pixel_valid), 32'd1);
    chk("lat_fs_n2", 32'(o_frame_start), 32'd1);
    chk("lat_pos_n2", 32'({o_pos_x, o_pos_y}), 32'd0);
    @(posedge i_clock);
    @(negedge i_clock) chk("lat_after_n3", 32'(o_pixel_valid), 32'd0);
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_active(input int lw, input int l2w, input int nl, input bit lat);
    int len;
    for (int l = 0; l < nl; l++) begin
      len = (l == 1) ? l2w : lw;
      for (int p = 0; p < len; p++) begin
        exp_q.push_back(pix(l == 0 && p == 0, p, l));
        if (lat && l == 0 && p == 0) lat_strobe();
        else strobe(1'b1);
      end
      repeat (8) strobe(1'b0);
    end
  endtask

  task automatic send_blank();
    repeat (48) strobe(1'b0);
  endtask

  task automatic chk_frame(input string tag, input int w, input int h, input bit l);
    chk({tag, "_width"}, 32'(o_width), 32'(w));
    chk({tag, "_height"}, 32'(o_height), 32'(h));
    chk({tag, "_locked"}, 32'(o_locked), 32'(l));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pv"}, 32'(o_pixel_valid), 32'd0);
    chk({tag, "_fs"}, 32'(o_frame_start), 32'd0);
    chk({tag, "_pos"}, 32'({o_pos_x, o_pos_y}), 32'd0);
    chk({tag, "_size"}, 32'({o_width, o_height}), 32'd0);
    chk({tag, "_locked"}, 32'(o_locked), 32'd0);
    chk({tag, "_error"}, 32'(o_error), 32'd0);
    chk({tag, "_state"}, 32'(o_state), 32'(HUNT));
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_w, cur_h, e0, p0, npix;
    bit cur_l;
    tbl[0] = '{16, 16, 4, 16, 4, 1'b0, 0};
    tbl[1] = '{16, 16, 4, 16, 4, 1'b1, 0};
    tbl[2] = '{16, 16, 4, 16, 4, 1'b1, 0};
    tbl[3] = '{16, 15, 4, 16, 4, 1'b0, 1};
    tbl[4] = '{16, 16, 4, 16, 4, 1'b0, 0};
    tbl[5] = '{16, 16, 4, 16, 4, 1'b1, 0};
    tbl[6] = '{12, 12, 4, 12, 4, 1'b0, 0};
    tbl[7] = '{12, 12, 4, 12, 4, 1'b1, 0};
    tbl[8] = '{12, 12, 3, 12, 3, 1'b0, 0};

    repeat (3) @(posedge i_clock);
    #1 chk_all_zero("reset");
    i_reset = 1'b1;
    repeat (24) strobe(1'b0);

    cur_w = 0; cur_h = 0; cur_l = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e0 = err_cnt;
      p0 = pix_cnt;
      send_active(tbl[i].lw, tbl[i].l2w, tbl[i].nl, 1'b0);
      chk("hold_size", 32'({o_width, o_height}), 32'({PW'(cur_w), PW'(cur_h)}));
      chk("hold_locked", 32'(o_locked), 32'(cur_l));
      send_blank();
      chk_frame("tbl", tbl[i].ew, tbl[i].eh, tbl[i].el);
      chk("tbl_errors", 32'(err_cnt - e0), 32'(tbl[i].eerr));
      npix = tbl[i].lw * (tbl[i].nl - 1) + tbl[i].l2w;
      chk("tbl_pixels", 32'(pix_cnt - p0), 32'(npix));
      cur_w = tbl[i].ew; cur_h = tbl[i].eh; cur_l = tbl[i].el;
    end

    send_active(16, 16, 4, 1'b1);
    send_blank();
    chk_frame("lat_frame", 16, 4, 1'b0);
    send_active(16, 16, 4, 1'b0);
    send_blank();
    chk_frame("relock", 16, 4, 1'b1);

    // DE stuck high runs x past 2047
    e0 = err_cnt;
    for (int p = 0; p < 2048; p++) begin
      if (p < 2047) exp_q.push_back(pix(p == 0, p, 0));
      strobe(1'b1);
    end
    chk("ovf_errors", 32'(err_cnt - e0), 32'd1);
    chk("ovf_state", 32'(o_state), 32'(HUNT));
    chk_frame("ovf_hold", 16, 4, 1'b0);
    repeat (24) strobe(1'b0);
    send_active(16, 16, 4, 1'b0);
    send_blank();
    chk_frame("after_ovf", 16, 4, 1'b0);

    // reset in the middle of line 1
    for (int p = 0; p < 16; p++) begin
      exp_q.push_back(pix(p == 0, p, 0));
      strobe(1'b1);
    end
    repeat (8) strobe(1'b0);
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back(pix(1'b0, p, 1));
      strobe(1'b1);
    end
    #3 i_reset = 1'b0;
    #1 chk_all_zero("async_rst");
    exp_q.delete();
    p0 = pix_cnt;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;
    repeat (8) strobe(1'b1);
    repeat (10) strobe(1'b0);
    repeat (16) strobe(1'b1);
    repeat (GAP - 1) strobe(1'b0);
    strobe(1'b1);
    chk("hunt_no_pixels", 32'(pix_cnt - p0), 32'd0);
    chk("hunt_state", 32'(o_state), 32'(HUNT));
    repeat (24) strobe(1'b0);
    p0 = pix_cnt;
    send_active(16, 16, 4, 1'b0);
    send_blank();
    chk_frame("after_rst", 16, 4, 1'b0);
    chk("after_rst_pixels", 32'(pix_cnt - p0), 32'd64);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_lcd_capture.md
Name: video_lcd_capture

Overview:
- Receiving end of the 800x480 LCD parallel timing interface: consumes a pixel-clock level and data-enable, and recovers scan position, frame/line framing and measured active resolution.
- Sits in the `i_clock` system domain. The pixel clock is treated as an oversampled data signal, not a clock.
- Used for loopback verification of the LCD timing generator and as the front end of a video-in path.

Parameters:
- `POS_WIDTH`, 11, width of position and size counters/outputs.
- `VGAP`, 512, consecutive pixel strobes with DE low that mark vertical blanking. Must exceed the longest horizontal blank and be below the vertical blank.
- `LOCK_FRAMES`, 2, consecutive identical error-free frames required to assert lock.

Ports:
- `i_clock`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_vga_clock`  in  1  pixel clock level, asynchronous to `i_clock`, period ≥ 4 `i_clock` cycles.
- `i_data_enable`  in  1  DE, changes with `i_vga_clock` rising edge.
- `o_pixel_valid`  out  1  one-cycle strobe per active pixel.
- `o_pos_x`  out  `POS_WIDTH`  column of current active pixel, 0-based.
- `o_pos_y`  out  `POS_WIDTH`  row of current active pixel, 0-based.
- `o_frame_start`  out  1  one-cycle strobe coincident with pixel (0,0).
- `o_width`  out  `POS_WIDTH`  active pixels per line, measured on last completed frame.
- `o_height`  out  `POS_WIDTH`  active lines, last completed frame.
- `o_locked`  out  1  stable timing detected.
- `o_error`  out  1  one-cycle strobe on line-width mismatch or counter overflow.

Behaviour:
- Reset (asynchronous, `i_reset`=0): all outputs 0, state HUNT, sync flops 0, lock counter 0.
- Sampling:
  - `i_vga_clock` and `i_data_enable` each pass through 2 flops.
  - `strobe` = synced clock high AND previous synced clock low.
  - DE is taken from the same synced stage as the strobe.
- Latency: for input edge N first sampling `i_vga_clock` high, `o_pixel_valid` is high during the cycle after edge N+2 and lasts exactly 1 cycle. `o_pos_x`/`o_pos_y` are valid in that same cycle.
- State machine, advancing only on `strobe`:
  - HUNT: count DE-low strobes; DE high resets the count. Count reaches `VGAP` → VBLANK. No pixel output in HUNT.
  - VBLANK, DE=1: emit pixel (0,0), `o_frame_start`=1, x←1, y←0, line_err←0 → ACTIVE.
  - ACTIVE, DE=1: emit pixel (x,y), x←x+1.
  - ACTIVE, DE=0: line_w←x; on first line of frame ref_w←x, else line_w≠ref_w sets line_err and pulses `o_error`; gap←1 → HBLANK.
  - HBLANK, DE=1: y←y+1, emit pixel (0,y+1), x←1 → ACTIVE.
  - HBLANK, DE=0: gap←gap+1. When gap reaches `VGAP`:
    - `o_height`←y+1, `o_width`←ref_w.
    - If ref_w and y+1 match the previous frame and no line_err: lock_cnt++ (saturating), else lock_cnt←0.
    - `o_locked` = lock_cnt ≥ `LOCK_FRAMES`-1 → VBLANK.
- Overflow: x or y would wrap past 2^`POS_WIDTH`-1 → pulse `o_error`, clear lock, → HUNT.
- `o_width`/`o_height`/`o_locked` update only at frame end and hold otherwise. Lock clears immediately on overflow or on a mismatched frame end.
- `i_vga_clock` stopped: no strobes, state frozen, outputs hold.
- Reset mid-frame: returns to HUNT. No pixel is emitted until a full `VGAP` gap has been seen.

Decomposition:
- Package `video_lcd_pkg`: state enum (HUNT, VBLANK, ACTIVE, HBLANK), default `POS_WIDTH`, and the 800x480 timing constants (HLINE 1056, HBACK 46, HFRONT 210, VLINE 525, VBACK 23, VFRONT 22), shared with the timing generator.
- Sub-module `video_sample_sync`: 2-flop synchronizers plus rising-edge detect producing `strobe` and synced DE.

Test Plan:
- Bench timing, `VGAP`=16, pixel period 4 cycles: 24-strobe lines (16 DE-high, 8 low), 6 lines per frame with 4 active. After the first full frame → `o_width`=16, `o_height`=4. 64 `o_pixel_valid` per frame, positions (0,0)..(15,3) in raster order.
- Same stream, 3 frames → `o_locked` rises at the end of frame 2 (first frame after HUNT counts as frame 1) and stays high.
- Lock established, then line 2 shortened to 15 active → `o_error` pulse at that line's DE fall, `o_locked`=0 at frame end. Recovers after 2 clean frames.
- Latency check: `i_vga_clock` rise sampled at edge N with DE=1 in VBLANK → `o_pixel_valid` and `o_frame_start` high only in the cycle after edge N+2, pos (0,0).
- Assert `i_reset`=0 mid-line 2 → all outputs 0 asynchronously. After release, no `o_pixel_valid` before a 16-strobe DE-low gap; next frame starts at (0,0).
- Full 800x480 timing (1056/525, `VGAP`=512) → `o_width`=800, `o_height`=480, `o_locked`=1 after 2 frames. DE held high for 2048 strobes → `o_error` pulse, state HUNT.
